// File: rtl/beta_mc_control.sv
// -----------------------------------------------------------------------------
// beta_mc_control
// Multi-cycle control unit for a Beta-style processor. A five-state FSM
// (FETCH, DECODE, EXEC, MEM, WB) sequences one instruction at a time. It
// latches the opcode during FETCH, checks for traps in DECODE, and drives the
// datapath selects and strobes from the latched opcode class.
//
// Ports
//   CLK, RESET        clock, synchronous active-high reset
//   IMEM_OP[5:0]      instruction bits [31:26]
//   MEM_RDY           memory handshake; completes the current access
//   Z                 register-file RD1==0 flag (sampled in EXEC)
//   IRQ, SUPER        level interrupt request, supervisor mode (PC[31])
//   PCSEL..ALU_OP     datapath selects
//   WERF, MOE, MWR    register-file write, memory read enable, memory write
//   IR_LOAD, PC_LOAD  instruction-register / PC load strobes
//   BUSY              high whenever the FSM is not in FETCH
//   DBG_STATE[2:0]    current FSM state (debug observation only)
//
// Handshake: a memory access (FETCH read, MEM read/write) is held with its
// strobe asserted on every cycle until a cycle in which MEM_RDY=1. That cycle
// completes the access, and the FSM leaves the state on the next edge.
// -----------------------------------------------------------------------------
module beta_mc_control (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [5:0] IMEM_OP,
   input  logic       MEM_RDY,
   input  logic       Z,
   input  logic       IRQ,
   input  logic       SUPER,
   output logic [2:0] PCSEL,
   output logic [1:0] WDSEL,
   output logic       RA2SEL,
   output logic       ASEL,
   output logic       BSEL,
   output logic       WASEL,
   output logic [3:0] ALU_OP,
   output logic       WERF,
   output logic       MOE,
   output logic       MWR,
   output logic       IR_LOAD,
   output logic       PC_LOAD,
   output logic       BUSY,
   output logic [2:0] DBG_STATE
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [5:0] r_op;
   logic       r_z;
   logic       r_trap_irq;
   logic       r_trap_ill;
   logic       r_rst_q;

   // Opcode classification of the latched instruction
   logic w_is_ld, w_is_st, w_is_jmp, w_is_beq, w_is_bne, w_is_ldr;
   logic w_is_alu, w_is_aluc, w_is_mem, w_legal;
   logic w_irq_trap, w_ill_trap, w_quiet;

   assign w_is_ld   = (r_op == 6'h18);
   assign w_is_st   = (r_op == 6'h19);
   assign w_is_jmp  = (r_op == 6'h1B);
   assign w_is_beq  = (r_op == 6'h1C);
   assign w_is_bne  = (r_op == 6'h1D);
   assign w_is_ldr  = (r_op == 6'h1F);
   // 0x27/0x2F/0x37/0x3F are exactly the ALU-range codes with low bits 111
   assign w_is_alu  = (r_op[5:4] == 2'b10) && (r_op[2:0] != 3'b111);
   assign w_is_aluc = (r_op[5:4] == 2'b11) && (r_op[2:0] != 3'b111);
   assign w_is_mem  = w_is_ld | w_is_st | w_is_ldr;
   assign w_legal   = w_is_mem | w_is_jmp | w_is_beq | w_is_bne |
                      w_is_alu | w_is_aluc;

   assign w_irq_trap = IRQ & ~SUPER;
   assign w_ill_trap = ~w_irq_trap & ~w_legal;

   // Outputs stay silent during reset and for one cycle after it
   assign w_quiet   = RESET | r_rst_q;
   assign DBG_STATE = r_state;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= S_FETCH;
         r_op       <= 6'h00;
         r_z        <= 1'b0;
         r_trap_irq <= 1'b0;
         r_trap_ill <= 1'b0;
         r_rst_q    <= 1'b1;
      end else begin
         r_rst_q <= 1'b0;
         r_state <= w_next;
         if (IR_LOAD) r_op <= IMEM_OP;
         if (r_state == S_EXEC) r_z <= Z;
         // Trap flags are refreshed every DECODE and consumed only in WB
         if (r_state == S_DECODE) begin
            r_trap_irq <= w_irq_trap;
            r_trap_ill <= w_ill_trap;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  if (!r_rst_q && MEM_RDY) w_next = S_DECODE;
         S_DECODE: w_next = (w_irq_trap || w_ill_trap) ? S_WB : S_EXEC;
         S_EXEC:   w_next = w_is_mem ? S_MEM : S_WB;
         S_MEM:    if (MEM_RDY) w_next = S_WB;
         S_WB:     w_next = S_FETCH;
         default:  w_next = S_FETCH;
      endcase
   end

   always_comb begin
      PCSEL   = 3'b000;
      WDSEL   = 2'b00;
      RA2SEL  = 1'b0;
      ASEL    = 1'b0;
      BSEL    = 1'b0;
      WASEL   = 1'b0;
      ALU_OP  = 4'h0;
      WERF    = 1'b0;
      MOE     = 1'b0;
      MWR     = 1'b0;
      IR_LOAD = 1'b0;
      PC_LOAD = 1'b0;
      BUSY    = 1'b0;
      if (!w_quiet) begin
         if (r_state == S_FETCH) begin
            MOE     = 1'b1;
            IR_LOAD = MEM_RDY;
         end else begin
            BUSY = 1'b1;
            // Class selects, stable from DECODE through WB
            if (w_is_alu || w_is_aluc) begin
               WDSEL  = 2'b01;
               BSEL   = w_is_aluc;
               ALU_OP = r_op[3:0];
            end
            if (w_is_ld) begin
               WDSEL = 2'b10;
               BSEL  = 1'b1;
            end
            if (w_is_st) begin
               RA2SEL = 1'b1;
               BSEL   = 1'b1;
            end
            if (w_is_ldr) begin
               ASEL   = 1'b1;
               WDSEL  = 2'b10;
               ALU_OP = 4'hF;
            end
            if (w_is_jmp) PCSEL = 3'b010;
            // Branch outcome uses the Z captured in EXEC, so it is only
            // meaningful (and only driven) in WB
            if (r_state == S_WB && ((w_is_beq && r_z) || (w_is_bne && !r_z)))
               PCSEL = 3'b001;

            if (r_state == S_MEM) begin
               MOE = w_is_ld | w_is_ldr;
               MWR = w_is_st;
            end

            if (r_state == S_WB) begin
               PC_LOAD = 1'b1;
               WERF    = ~w_is_st;
               if (r_trap_irq || r_trap_ill) begin
                  PCSEL  = r_trap_irq ? 3'b100 : 3'b011;
                  WDSEL  = 2'b00;
                  RA2SEL = 1'b0;
                  ASEL   = 1'b0;
                  BSEL   = 1'b0;
                  ALU_OP = 4'h0;
                  WASEL  = 1'b1;
                  WERF   = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: doc/beta_mc_control.md
BETA_MC_CONTROL -- requirements
Module: beta_mc_control

Interface
REQ-001 The block SHALL have one clock, CLK, and a synchronous, active-high reset, RESET. RESET is sampled on the CLK rising edge.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- CLK  in  1  clock
- RESET  in  1  sync active-high reset
- IMEM_OP  in  6  instruction-memory data bits [31:26]
- MEM_RDY  in  1  memory handshake; completes the current access
- Z  in  1  RD1==0 flag from the register file
- IRQ  in  1  level interrupt request
- SUPER  in  1  PC[31]; supervisor mode
- PCSEL  out  3  PC mux select
- WDSEL  out  2  write-data select
- RA2SEL  out  1  RA2 select
- ASEL  out  1  A operand select
- BSEL  out  1  B operand select
- WASEL  out  1  write-address select
- ALU_OP  out  4  ALU function
- WERF  out  1  register-file write strobe
- MOE  out  1  memory output enable (read)
- MWR  out  1  memory write strobe
- IR_LOAD  out  1  instruction-register load strobe
- PC_LOAD  out  1  PC load strobe
- BUSY  out  1  high when not in FETCH

Function
REQ-003 The block SHALL implement a five-state FSM: FETCH, DECODE, EXEC, MEM, WB.
REQ-004 FETCH: MOE=1. The FSM SHALL stay in FETCH while MEM_RDY=0. When MEM_RDY=1: IR_LOAD=1 that cycle, IMEM_OP is latched into the internal opcode register, and the next state is DECODE.
REQ-005 The internal opcode register SHALL be classified as follows:
- LD 0x18, ST 0x19, JMP 0x1B, BEQ 0x1C, BNE 0x1D, LDR 0x1F
- ALU 0x20-0x2F, ALUC 0x30-0x3F
- Illegal: any other value, and 0x27, 0x2F, 0x37, 0x3F.
REQ-006 DECODE, trap check:
- If IRQ=1 and SUPER=0, the FSM SHALL take the IRQ trap.
- Else, if the opcode is illegal, it SHALL take the ILLOP trap.
- Else, next state is EXEC.
- IRQ has priority when both conditions hold.
REQ-007 A trap SHALL go DECODE -> WB with PCSEL=100 (IRQ) or 011 (ILLOP), WDSEL=00, WASEL=1, WERF=1, PC_LOAD=1 in WB.
REQ-008 EXEC lasts exactly one cycle. Next state is MEM for LD/ST/LDR and WB for all other instructions.
REQ-009 MEM:
- LD/LDR: MOE=1.
- ST: MWR=1 and WERF=0.
- The FSM SHALL hold in MEM while MEM_RDY=0 and go to WB on MEM_RDY=1.
REQ-010 WB: PC_LOAD=1 for exactly one cycle. WERF=1 for every instruction except ST. Next state is FETCH.
REQ-011 Select encodings per class (held stable from DECODE through WB):
- ALU: WDSEL=01, BSEL=0, ASEL=0, RA2SEL=0, PCSEL=000.
- ALUC: as ALU but BSEL=1.
- LD: WDSEL=10, BSEL=1, ALU_OP=0 (ADD).
- ST: RA2SEL=1, BSEL=1, ALU_OP=0.
- LDR: ASEL=1, WDSEL=10, ALU_OP=4'hF (pass A).
- JMP: PCSEL=010, WDSEL=00.
- BEQ: PCSEL=001 if Z=1, else 000; WDSEL=00.
- BNE: PCSEL=001 if Z=0, else 000; WDSEL=00.
- WASEL=0 except on traps.
REQ-012 For ALU/ALUC, ALU_OP SHALL equal opcode[3:0]. For every other class not listed in REQ-011, ALU_OP SHALL be 0.
REQ-013 Z SHALL be sampled in EXEC and held for the branch decision in WB. A change in Z during WB SHALL NOT alter PCSEL.
REQ-014 WERF, MWR, IR_LOAD and PC_LOAD SHALL be asserted only in the states named above and SHALL never be high at the same time as each other except WERF with PC_LOAD in WB.
REQ-015 In FETCH, all selects SHALL be 0 and PCSEL=000.
REQ-016 IRQ asserted outside DECODE SHALL NOT be acted on until the next DECODE.
REQ-017 With zero wait states:
- ALU/ALUC/JMP/branch: 4 cycles (FETCH, DECODE, EXEC, WB).
- LD/ST/LDR: 5 cycles.
- Trap: 3 cycles (FETCH, DECODE, WB).

Reset
REQ-018 When RESET=1 at a clock edge, the next state SHALL be FETCH and the opcode register SHALL clear to 0. This applies in any state, including mid-MEM wait.
REQ-019 While in reset, and in the cycle following reset, all strobes (WERF, MWR, MOE, IR_LOAD, PC_LOAD) SHALL be 0. All selects and ALU_OP SHALL be 0, and BUSY SHALL be 0.
REQ-020 RESET SHALL take precedence over MEM_RDY and IRQ in the same cycle.

Verification
REQ-021 ADD (0x20), MEM_RDY=1 constant, IRQ=0 -> states FETCH, DECODE, EXEC, WB. In WB: WERF=1, PC_LOAD=1, WDSEL=01, BSEL=0, ALU_OP=0. Back in FETCH on cycle 5.
REQ-022 LD (0x18), MEM_RDY low for 3 cycles in MEM -> MOE=1 for 3+1 cycles. In WB: WDSEL=10, BSEL=1, WERF=1. ST (0x19) -> MWR=1 in MEM, RA2SEL=1, WERF=0 in WB.
REQ-023 BEQ with Z=1 in EXEC and Z=0 in WB -> PCSEL=001 in WB, WERF=1, WDSEL=00. BNE with Z=1 -> PCSEL=000.
REQ-024 Opcode 0x27 -> DECODE then WB with PCSEL=011, WASEL=1, WDSEL=00, WERF=1. IRQ=1 with SUPER=0 on the same instruction -> PCSEL=100. IRQ=1 with SUPER=1 -> no IRQ trap; ILLOP is still taken.
REQ-025 RESET asserted in MEM during an ST with MEM_RDY=0 -> next cycle is FETCH, MWR=0, and no WB pulse occurs.
